// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the display controller and whoever drives it: the value and
// load request go in, and the status, digit enables and segments come out.
interface seven_seg_scan_ctrl_if;
   logic [7:0] value;     // binary value to display, taken when a load is accepted
   logic       load;      // conversion request
   logic       blank_lz;  // leading-zero blanking enable, used live
   logic       busy;      // conversion in progress
   logic       done;      // one-cycle pulse: new digits are on the display
   logic [2:0] an_n;      // active-low digit enables: bit0 ones, bit1 tens, bit2 hundreds
   logic [7:0] display;   // segments a..g in bits 0..6, bit 7 always 0

   modport master (
      output value, load, blank_lz,
      input  busy, done, an_n, display
   );

   modport slave (
      input  value, load, blank_lz,
      output busy, done, an_n, display
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Three-digit multiplexed seven-segment controller. An 8-bit value is turned
// into BCD with a double-dabble FSM, one shift per clock, and the finished
// digits are copied into the display registers in a single step. A free-running
// refresh counter scans the ones, tens and hundreds digits in turn.

// Team 4-bit seven-segment decoder: 0..9 light the usual segments, and every
// other code leaves all segments off.
module seg7_decoder (
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);
   // Map one BCD digit to segments a..g (bit 0 = a).
   always_comb begin
      // NOTE: giving every combinational output a default before the case means
      // no path leaves it unassigned, so no latch is inferred.
      seg_o = 7'h00;
      case (digit_i)
         4'd0:    seg_o = 7'h3F;
         4'd1:    seg_o = 7'h06;
         4'd2:    seg_o = 7'h5B;
         4'd3:    seg_o = 7'h4F;
         4'd4:    seg_o = 7'h66;
         4'd5:    seg_o = 7'h6D;
         4'd6:    seg_o = 7'h7D;
         4'd7:    seg_o = 7'h07;
         4'd8:    seg_o = 7'h7F;
         4'd9:    seg_o = 7'h6F;
         default: seg_o = 7'h00;
      endcase
   end
endmodule

module seven_seg_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 50000  // cycles each digit stays lit, 2..2^20
) (
   input logic                 clk,
   input logic                 rst_n,
   seven_seg_scan_ctrl_if.slave bus
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_UPDATE  = 2'd2;

   // 20 bits reach the largest terminal count, 2^20 - 1.
   localparam int unsigned     CNT_W    = 20;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   localparam logic [1:0] DIG_ONES = 2'd0;
   localparam logic [1:0] DIG_TENS = 2'd1;
   localparam logic [1:0] DIG_HUND = 2'd2;

   logic [1:0]       state_q,   state_d;
   logic [7:0]       bin_q,     bin_d;      // binary bits still to be shifted in
   logic [11:0]      bcd_q,     bcd_d;      // hundreds/tens/ones scratch nibbles
   logic [2:0]       step_q,    step_d;     // shift steps already taken
   logic [3:0]       hund_q,    hund_d;
   logic [3:0]       tens_q,    tens_d;
   logic [3:0]       ones_q,    ones_d;
   logic             done_q,    done_d;
   logic [CNT_W-1:0] refresh_q, refresh_d;
   logic [1:0]       idx_q,     idx_d;

   logic [11:0] bcd_adj;
   logic        blank_hund;
   logic        blank_tens;
   logic [3:0]  dec_digit;
   logic [6:0]  dec_seg;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM: latch the value, shift eight times, then publish the digits.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      step_d  = step_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.load) begin
               bin_d   = bus.value;
               bcd_d   = '0;
               step_d  = '0;
               state_d = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            bcd_d  = {bcd_adj[10:0], bin_q[7]};
            bin_d  = {bin_q[6:0], 1'b0};
            step_d = step_q + 3'd1;
            if (step_q == 3'd7) begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            hund_d  = bcd_q[11:8];
            tens_d  = bcd_q[7:4];
            ones_d  = bcd_q[3:0];
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Refresh counter and digit rotation ones -> tens -> hundreds -> ones.
   always_comb begin
      refresh_d = refresh_q + 1'b1;
      idx_d     = idx_q;
      if (refresh_q == CNT_LAST) begin
         refresh_d = '0;
         idx_d     = (idx_q == DIG_HUND) ? DIG_ONES : idx_q + 2'd1;
      end
   end

   // All state registers; each takes its next-state value on the rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         step_q    <= '0;
         hund_q    <= '0;
         tens_q    <= '0;
         ones_q    <= '0;
         done_q    <= 1'b0;
         refresh_q <= '0;
         idx_q     <= DIG_ONES;
      end else begin
         // NOTE: non-blocking assignments let every register read the
         // pre-edge value of the others, which is what real flops do.
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         step_q    <= step_d;
         hund_q    <= hund_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         done_q    <= done_d;
         refresh_q <= refresh_d;
         idx_q     <= idx_d;
      end
   end

   // Leading zeros: hundreds blank when zero; tens blank only behind a blank hundreds.
   assign blank_hund = bus.blank_lz && (hund_q == 4'd0);
   assign blank_tens = blank_hund && (tens_q == 4'd0);

   // Pick the active digit for the decoder and its enable; 4'hF shows nothing.
   always_comb begin
      dec_digit  = ones_q;
      bus.an_n   = 3'b110;
      case (idx_q)
         DIG_TENS: begin
            dec_digit = blank_tens ? 4'hF : tens_q;
            bus.an_n  = 3'b101;
         end
         DIG_HUND: begin
            dec_digit = blank_hund ? 4'hF : hund_q;
            bus.an_n  = 3'b011;
         end
         default: begin
            dec_digit = ones_q;
            bus.an_n  = 3'b110;
         end
      endcase
   end

   seg7_decoder u_dec (
      .digit_i (dec_digit),
      .seg_o   (dec_seg)
   );

   assign bus.display = {1'b0, dec_seg};
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl. Two copies run side by side on the same
// inputs, one scanning every 2 cycles and one every 5. A reference model
// predicts busy/done from a countdown and the display from decimal arithmetic.
module tb_seven_seg_scan_ctrl;
   localparam int unsigned DIV_A = 2;
   localparam int unsigned DIV_B = 5;

   localparam logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                       8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   seven_seg_scan_ctrl_if bus_a ();
   seven_seg_scan_ctrl_if bus_b ();

   assign bus_b.value    = bus_a.value;
   assign bus_b.load     = bus_a.load;
   assign bus_b.blank_lz = bus_a.blank_lz;

   seven_seg_scan_ctrl #(.REFRESH_DIV(DIV_A)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   seven_seg_scan_ctrl #(.REFRESH_DIV(DIV_B)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: cycles since reset, a busy countdown, the shown value.
   int n_cyc    = 0;
   int busy_cnt = 0;
   int pend     = 0;
   int shown    = 0;
   bit exp_done = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_cyc    = 0;
         busy_cnt = 0;
         shown    = 0;
         exp_done = 1'b0;
      end else begin
         n_cyc++;
         exp_done = 1'b0;
         if (busy_cnt == 0) begin
            if (bus_a.load) begin
               busy_cnt = 9;
               pend     = int'(bus_a.value);
            end
         end else begin
            busy_cnt--;
            if (busy_cnt == 0) begin
               shown    = pend;
               exp_done = 1'b1;
            end
         end
      end
   end

   function automatic int exp_pos(input int div);
      return (n_cyc / div) % 3;
   endfunction

   function automatic logic [2:0] exp_an(input int div);
      int p = exp_pos(div);
      return (p == 0) ? 3'b110 : (p == 1) ? 3'b101 : 3'b011;
   endfunction

   function automatic logic [7:0] exp_disp(input int div);
      int p = exp_pos(div);
      int d [3];
      bit blank = 1'b0;
      d[0] = shown % 10;
      d[1] = (shown / 10) % 10;
      d[2] = shown / 100;
      if (bus_a.blank_lz && p == 2 && d[2] == 0) blank = 1'b1;
      if (bus_a.blank_lz && p == 1 && d[2] == 0 && d[1] == 0) blank = 1'b1;
      return blank ? 8'h00 : SEG[d[p]];
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " busy_a"}, {7'b0, bus_a.busy}, {7'b0, busy_cnt != 0});
      chk({tag, " busy_b"}, {7'b0, bus_b.busy}, {7'b0, busy_cnt != 0});
      chk({tag, " done_a"}, {7'b0, bus_a.done}, {7'b0, exp_done});
      chk({tag, " done_b"}, {7'b0, bus_b.done}, {7'b0, exp_done});
      chk({tag, " an_a"},   {5'b0, bus_a.an_n}, {5'b0, exp_an(DIV_A)});
      chk({tag, " an_b"},   {5'b0, bus_b.an_n}, {5'b0, exp_an(DIV_B)});
      chk({tag, " disp_a"}, bus_a.display,      exp_disp(DIV_A));
      chk({tag, " disp_b"}, bus_b.display,      exp_disp(DIV_B));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   // Step until done is seen (bounded); lat is the number of edges taken.
   task automatic wait_done(input string tag, output int lat);
      bit got = 1'b0;
      lat = 0;
      while (!got && lat < 20) begin
         step(tag);
         lat++;
         if (bus_a.done === 1'b1) got = 1'b1;
      end
   endtask

   // Step until the fast copy lights the given digit, then check its segments.
   task automatic wait_digit(input logic [2:0] an_pat, input logic [7:0] disp, input string tag);
      int k = 0;
      while (bus_a.an_n !== an_pat && k < 12) begin
         step(tag);
         k++;
      end
      chk({tag, " an"},  {5'b0, bus_a.an_n}, {5'b0, an_pat});
      chk({tag, " seg"}, bus_a.display, disp);
   endtask

   task automatic start_load(input logic [7:0] v, input string tag);
      bus_a.value = v;
      bus_a.load  = 1'b1;
      step(tag);
      bus_a.load  = 1'b0;
   endtask

   initial begin
      int lat;
      int dones;
      bus_a.value    = 8'd0;
      bus_a.load     = 1'b0;
      bus_a.blank_lz = 1'b0;

      // Reset values appear as soon as rst_n falls.
      #2 rst_n = 1'b0;
      #1;
      check_all("reset");
      chk("reset an", {5'b0, bus_a.an_n}, 8'h06);
      chk("reset disp", bus_a.display, 8'h3F);
      run(2, "in_reset");

      // Release and load 255 on the very first edge.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_load(8'd255, "load255");
      chk("busy after load", {7'b0, bus_a.busy}, 8'h01);
      wait_done("lat255", lat);
      chk("latency 255", 8'(lat), 8'd9);
      wait_digit(3'b110, 8'h6D, "255 ones");
      wait_digit(3'b101, 8'h6D, "255 tens");
      wait_digit(3'b011, 8'h5B, "255 hund");

      // Value 7 with and without leading-zero blanking.
      bus_a.blank_lz = 1'b1;
      start_load(8'd7, "load7");
      wait_done("lat7", lat);
      wait_digit(3'b110, 8'h07, "7 ones");
      wait_digit(3'b101, 8'h00, "7 tens blank");
      wait_digit(3'b011, 8'h00, "7 hund blank");
      bus_a.blank_lz = 1'b0;
      wait_digit(3'b101, 8'h3F, "7 tens shown");
      wait_digit(3'b011, 8'h3F, "7 hund shown");

      // A load during the conversion of 94 is ignored.
      start_load(8'd94, "load94");
      run(3, "conv94");
      start_load(8'd40, "ignored40");
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         step("count94");
         if (bus_a.done === 1'b1) dones++;
      end
      chk("one done 94", 8'(dones), 8'd1);
      wait_digit(3'b110, 8'h66, "94 ones");
      wait_digit(3'b101, 8'h6F, "94 tens");
      wait_digit(3'b011, 8'h3F, "94 hund");

      // Back-to-back: a load on the done cycle of 100 is accepted.
      start_load(8'd100, "load100");
      wait_done("lat100", lat);
      chk("latency 100", 8'(lat), 8'd9);
      bus_a.value = 8'd1;
      bus_a.load  = 1'b1;
      wait_done("gap", lat);
      bus_a.load  = 1'b0;
      chk("done gap", 8'(lat), 8'd10);
      wait_digit(3'b110, 8'h06, "1 ones");
      wait_digit(3'b101, 8'h3F, "1 tens");
      wait_digit(3'b011, 8'h3F, "1 hund");

      // Load landing on a digit wrap of the fast copy.
      if (n_cyc % DIV_A != DIV_A - 1) step("align");
      start_load(8'd123, "load_wrap");
      run(14, "wrap_scan");

      // Reset in the middle of converting 200.
      start_load(8'd200, "load200");
      run(4, "conv200");
      rst_n = 1'b0;
      #1;
      check_all("mid_reset");
      chk("mid_reset busy", {7'b0, bus_a.busy}, 8'h00);
      chk("mid_reset disp", bus_a.display, 8'h3F);
      run(2, "held_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         step("after_reset");
         if (bus_a.done === 1'b1) dones++;
      end
      chk("no done after reset", 8'(dones), 8'd0);

      // Randomized loads, values and blanking against the model.
      for (int i = 0; i < 400; i++) begin
         bus_a.load  = ($urandom_range(0, 9) < 3);
         bus_a.value = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) < 2) bus_a.blank_lz = ~bus_a.blank_lz;
         step("random");
      end
      bus_a.load = 1'b0;
      run(12, "drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
